// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes.
// S1 holds operands, S2 holds the result, flags and accumulator.
module logic_unit_pipe #(
  parameter int W       = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       y,
  output logic               zero,
  output logic               parity,
  output logic [W-1:0]       acc,
  output logic [COUNT_W-1:0] count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTA = 3'd6;
  localparam logic [2:0] OP_ACCN = 3'd7;

  logic               s1_valid_q, s1_valid_d;
  logic [W-1:0]       s1_a_q, s1_a_d;
  logic [W-1:0]       s1_b_q, s1_b_d;
  logic [2:0]         s1_op_q, s1_op_d;
  logic               s2_valid_q, s2_valid_d;
  logic [W-1:0]       y_q, y_d;
  logic               zero_q, zero_d;
  logic               parity_q, parity_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               s1_adv;
  logic               s2_adv;
  logic [W-1:0]       res;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    res = '0;
    unique case (s1_op_q)
      OP_AND:  res = s1_a_q & s1_b_q;
      OP_OR:   res = s1_a_q | s1_b_q;
      OP_NAND: res = ~(s1_a_q & s1_b_q);
      OP_NOR:  res = ~(s1_a_q | s1_b_q);
      OP_XOR:  res = s1_a_q ^ s1_b_q;
      OP_XNOR: res = ~(s1_a_q ^ s1_b_q);
      OP_NOTA: res = ~s1_a_q;
      OP_ACCN: res = ~(s1_a_q & acc_q);
      default: res = '0;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d  = a;
        s1_b_d  = b;
        s1_op_d = op;
      end
    end
  end

  // acc advances only when an op-7 result enters S2, so chains stay ordered
  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    acc_d      = acc_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d      = res;
        zero_d   = (res == '0);
        parity_d = ^res;
        if (s1_op_q == OP_ACCN) acc_d = res;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (s2_valid_q && out_ready) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      acc_q      <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      zero_q     <= zero_d;
      parity_q   <= parity_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign acc       = acc_q;
  assign count     = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model plus
// a W=1 instance for the single-bit gate case.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y, acc;
  logic [2:0] op;
  logic       zero, parity;
  logic [3:0] count;

  logic       v1, r1, ov1, ordy1, a1, b1, y1, z1, p1, acc1;
  logic [2:0] op1;
  logic [7:0] cnt1;

  logic_unit_pipe #(.W(8), .COUNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity),
    .acc(acc), .count(count)
  );

  logic_unit_pipe #(.W(1), .COUNT_W(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(r1),
    .a(a1), .b(b1), .op(op1),
    .out_valid(ov1), .out_ready(ordy1),
    .y(y1), .zero(z1), .parity(p1),
    .acc(acc1), .count(cnt1)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] acc_after;
    int         stamp;
  } item_t;

  item_t      q[$];
  int         n_edges;
  int         n_chk;
  int         n_fail;
  logic [7:0] m_acc_tail;
  logic [7:0] m_acc_done;
  logic [3:0] m_cnt;

  function automatic logic [7:0] ref_op(
    input logic [2:0] o, input logic [7:0] x, z, t);
    case (o)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return ~(x & z);
      3'd3:    return ~(x | z);
      3'd4:    return x ^ z;
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return ~(x & t);
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs, exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input logic [7:0] ia, ib,
                     input logic [2:0] iop, input logic ordy,
                     output bit took);
    bit    exp_rdy, exp_ov;
    logic [7:0] r;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = (q.size() > 0) && (n_edges > q[0].stamp);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check("acc", {24'd0, acc},
          {24'd0, exp_ov ? q[0].acc_after : m_acc_done});
    check("count", {28'd0, count}, {28'd0, m_cnt});
    if (exp_ov) begin
      check("y", {24'd0, y}, {24'd0, q[0].res});
      check("zero", {31'd0, zero}, {31'd0, q[0].res == 8'd0});
      check("parity", {31'd0, parity}, {31'd0, ^q[0].res});
    end
    @(posedge clk);
    n_edges++;
    if (exp_ov && ordy) begin
      m_acc_done = q[0].acc_after;
      void'(q.pop_front());
      m_cnt++;
    end
    took = iv && exp_rdy;
    if (took) begin
      r = ref_op(iop, ia, ib, m_acc_tail);
      if (iop == 3'd7) m_acc_tail = r;
      q.push_back('{r, m_acc_tail, n_edges});
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; v1 = 1'b0;
    @(posedge clk);
    n_edges++;
    q.delete();
    m_acc_tail = 8'd0; m_acc_done = 8'd0; m_cnt = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", {24'd0, y}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_parity", {31'd0, parity}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
  endtask

  initial begin
    bit         took;
    int         sent;
    logic [3:0] yexp;
    logic [7:0] accseq_a [5];
    logic [2:0] accseq_op [5];
    n_chk = 0; n_fail = 0; n_edges = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    v1 = 1'b0; ordy1 = 1'b0; a1 = 1'b0; b1 = 1'b0; op1 = 3'd0;
    reset_dut();

    // single-bit NAND truth table through the W=1 instance
    yexp = 4'b0111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v1 = (i < 4); a1 = i[1]; b1 = i[0]; op1 = 3'd2; ordy1 = 1'b1;
      #1;
      if (i >= 2) begin
        check("w1_valid", {31'd0, ov1}, 32'd1);
        check("w1_y", {31'd0, y1}, {31'd0, yexp[i-2]});
        check("w1_zero", {31'd0, z1}, {31'd0, ~yexp[i-2]});
      end
    end
    @(negedge clk);
    v1 = 1'b0;
    #1;
    check("w1_count", {24'd0, cnt1}, 32'd4);
    check("w1_idle", {31'd0, ov1}, 32'd0);

    // ops 0..6 back-to-back on fixed operands
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1, took);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, took);

    // XOR stream with output stalled for five cycles
    sent = 0;
    for (int i = 0; i < 14; i++) begin
      cyc(sent < 5, 8'($urandom), 8'($urandom), 3'd4,
          !(i >= 2 && i <= 6), took);
      if (took) sent++;
    end
    check("bp_sent", sent, 32'd5);

    // accumulator chain with interleaved AND
    reset_dut();
    accseq_a  = '{8'hFF, 8'h55, 8'hFF, 8'h3C, 8'h0F};
    accseq_op = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd7};
    for (int i = 0; i < 5; i++)
      cyc(1'b1, accseq_a[i], 8'hAA, accseq_op[i], 1'b1, took);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, took);
    check("acc_final", {24'd0, acc}, 32'hFF);

    // 17 completions wrap the 4-bit counter
    for (int i = 0; i < 17; i++)
      cyc(1'b1, 8'($urandom), 8'($urandom),
          3'($urandom_range(0, 7)), 1'b1, took);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, took);

    // reset with both stages full, then restart
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'($urandom), 8'($urandom), 3'd7, 1'b0, took);
    reset_dut();
    cyc(1'b1, 8'hA5, 8'h0F, 3'd7, 1'b1, took);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, took);

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
          3'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0), took);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, took);
    check("drained", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit that generalises the single-bit two-input gate family (AND/OR/NAND/NOR/XOR/XNOR) to W-bit operands with a runtime-selectable operation. It adds an accumulating NAND mode, result flags and a transaction counter. Input and output use valid/ready handshakes, so the block can sit between a register-file read port and a writeback stage in the lab datapath.

Parameters:
W, 8, operand/result width in bits (W >= 1)
COUNT_W, 8, width of completed-transaction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand/op presented
in_ready  output  1  block accepts operands this cycle
a  input  W  operand A
b  input  W  operand B (ignored for op 6 and op 7)
op  input  3  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
y  output  W  result
zero  output  1  y == 0
parity  output  1  XOR-reduction of y
acc  output  W  accumulator state
count  output  COUNT_W  completed transactions, modulo 2^COUNT_W

Behaviour:
- Reset (synchronous, active-high, sampled on rising clk) clears s1_valid, s2_valid and all of the following: out_valid=0, y=0, zero=0, parity=0, acc=0, count=0. Reset takes priority over every other event, including mid-pipeline transactions. In-flight data is discarded, not delivered.
- Op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 ACC_NAND (result = ~(a & acc)). All ops are bitwise over W bits.
- Pipeline: stage S1 registers a, b and op. Stage S2 computes the op and registers y, zero and parity.
  - Latency from accept (in_valid && in_ready) to out_valid is 2 cycles when not stalled.
  - Throughput is 1 transaction per cycle.
- Handshake and stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is a combinational path from out_ready and is permitted.
  - S2 loads from S1 when s2_adv. s2_valid then takes s1_valid.
  - S1 loads when s1_adv. s1_valid then takes in_valid.
  - When out_valid=1 and out_ready=0, y, zero, parity and out_valid hold stable. Operands must never be lost or duplicated.
- Accumulator:
  - acc updates only when an op-7 transaction loads into S2, with acc <= ~(a & acc). y receives the same value.
  - Back-to-back op-7 transactions chain correctly, each using the acc value produced by the previous one.
  - Non-op-7 transactions leave acc unchanged.
- Counter: count increments on each out_valid && out_ready and wraps from 2^COUNT_W-1 to 0.
- Simultaneous events:
  - Accept and output in the same cycle are legal and keep the pipeline full.
  - acc update and count increment in the same cycle are independent.
- Flags are registered together with y and always correspond to the currently held y.
- Inputs are sampled only on accept. Changes to a, b or op while in_ready=0 have no effect.

Test Plan:
- W=1, op=2, out_ready=1; apply (a,b) = (0,0), (0,1), (1,0), (1,1) on consecutive cycles -> y = 1, 1, 1, 0 on cycles 2..5 after the first accept; zero = 0, 0, 0, 1; count=4.
- W=8, a=8'hF0, b=8'hCC, ops 0..6 back-to-back -> y = CC&F0=C0, FC, 3F, 03, 3C, C3, 0F in order; parity = 0, 0, 0, 0, 0, 0, 0; no bubbles.
- Backpressure: stream 5 XOR transactions and hold out_ready=0 for cycles 3..7 -> in_ready=0 once S1 and S2 are full; y is stable while stalled; after release all 5 results arrive in order with none lost or duplicated.
- ACC chain with W=8 from reset: op=7 with a = FF, FF, 0F -> y = FF, 00, FF; acc ends at FF. An interleaved op=0 between them leaves acc unchanged.
- Counter wrap with COUNT_W=4: complete 17 transactions -> count goes 15 -> 0 -> 1.
- Reset mid-operation: assert rst for 1 cycle with both stages valid -> next cycle out_valid=0, acc=0, count=0, y=0; the first new accept produces a result 2 cycles later.
